// File: rtl/dat_mem_arbiter_if.sv
// Requester and memory-side signals of the two-port data memory arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and models the memory.
interface dat_mem_arbiter_if;
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_wr_en;
  logic [7:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rdata0, rdata1, mem_addr, mem_din, mem_wr_en
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rdata0, rdata1, mem_addr, mem_din, mem_wr_en
  );
endinterface

// File: rtl/dat_mem_arbiter.sv
// Round-robin arbiter sharing one 8x256 data memory between two ports; grant 1 cycle after req, reads 0 cycles after grant.
// Backpressure: a losing port holds req until gnt; bursts are capped at MAX_BURST beats while the other port waits.
module dat_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dat_mem_arbiter_if.slave   bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic          last_owner;
  logic [CW-1:0] beat_cnt;
  logic          own0;
  logic          own1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the port that did not own the memory last wins.
          if (bus.req0 && (!bus.req1 || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            beat_cnt   <= '0;
          end else if (bus.req1) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
          end
        end
        OWN0: begin
          if (bus.req0 && !(bus.req1 && beat_cnt == CNT_LAST)) begin
            if (beat_cnt != CNT_LAST) beat_cnt <= beat_cnt + CW'(1);
          end else if (bus.req1) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        OWN1: begin
          if (bus.req1 && !(bus.req0 && beat_cnt == CNT_LAST)) begin
            if (beat_cnt != CNT_LAST) beat_cnt <= beat_cnt + CW'(1);
          end else if (bus.req0) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            beat_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  assign bus.gnt0 = own0;
  assign bus.gnt1 = own1;

  // Steering follows the async-reset state, so reset kills a pending write before its falling edge.
  assign bus.mem_addr  = own0 ? bus.addr0  : (own1 ? bus.addr1  : 8'h00);
  assign bus.mem_din   = own0 ? bus.wdata0 : (own1 ? bus.wdata1 : 8'h00);
  assign bus.mem_wr_en = (own0 & bus.req0 & bus.we0) | (own1 & bus.req1 & bus.we1);

  assign bus.rdata0 = own0 ? bus.mem_dout : 8'h00;
  assign bus.rdata1 = own1 ? bus.mem_dout : 8'h00;
endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed bench for dat_mem_arbiter with a behavioural 8x256 memory (combinational read, falling-edge write).
module tb_dat_mem_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] mem [256];

  dat_mem_arbiter_if bus ();

  dat_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] <= bus.mem_din;
  end

  // Advance to 2 time units after the next rising edge; inputs set afterwards belong to that cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    total++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", bus.gnt0, bus.gnt1); end
    total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", bus.mem_addr); end
    total++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=00/00", bus.rdata0, bus.rdata1); end
    // Release reset, get a write granted, then pull reset mid-cycle.
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h33; bus.wdata0 = 8'h77;
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL pre_rst_grant got gnt0=%b wr=%b exp 1 1", bus.gnt0, bus.mem_wr_en); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL async_rst_gnt0 got=%b exp=0", bus.gnt0); end
    total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL async_rst_wr_en got=%b exp=0", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL async_rst_addr got=%h exp=00", bus.mem_addr); end
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    @(negedge clk);
    #1;
    total++; if (mem[8'h33] !== 8'h00) begin bad++; $display("FAIL async_rst_nowrite got=%h exp=00", mem[8'h33]); end
    rst_n = 1'b1;
    repeat (3) tick();
    #1;
    total++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL idle_after_rst got=%b%b exp=00", bus.gnt0, bus.gnt1); end
  endtask

  task automatic test_single_write_read();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
    #1;
    total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL wr_latency got gnt0=%b exp=0", bus.gnt0); end
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b1) begin bad++; $display("FAIL wr_gnt0 got=%b exp=1", bus.gnt0); end
    total++; if (bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL wr_en got=%b exp=1", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'h10 || bus.mem_din !== 8'hA5) begin bad++; $display("FAIL wr_bus got=%h/%h exp=10/a5", bus.mem_addr, bus.mem_din); end
    @(negedge clk);
    #1;
    total++; if (mem[8'h10] !== 8'hA5) begin bad++; $display("FAIL wr_commit got=%h exp=a5", mem[8'h10]); end
    bus.we0 = 1'b0;
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.rdata0 !== 8'hA5) begin bad++; $display("FAIL rd_data got gnt0=%b rdata0=%h exp 1 a5", bus.gnt0, bus.rdata0); end
    total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rd_wr_en got=%b exp=0", bus.mem_wr_en); end
    tick();
    bus.req0 = 1'b0;
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rd_bubble got gnt0=%b wr=%b exp 1 0", bus.gnt0, bus.mem_wr_en); end
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("FAIL rd_idle got gnt0=%b exp=0", bus.gnt0); end
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL tie_first got=%b%b exp=10", bus.gnt0, bus.gnt1); end
    tick();
    bus.req0 = 1'b0;
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL tie_bubble got=%b%b wr=%b exp=10 wr=0", bus.gnt0, bus.gnt1, bus.mem_wr_en); end
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin bad++; $display("FAIL tie_switch got=%b%b exp=01", bus.gnt0, bus.gnt1); end
    total++; if (bus.rdata1 !== 8'hA5 || bus.rdata0 !== 8'h00) begin bad++; $display("FAIL tie_rdata got=%h/%h exp=00/a5", bus.rdata0, bus.rdata1); end
    tick();
    bus.req1 = 1'b0;
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL tie_idle got=%b%b exp=00", bus.gnt0, bus.gnt1); end
  endtask

  task automatic test_contention();
    logic exp0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h00; bus.wdata0 = 8'h50;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h80; bus.wdata1 = 8'hE0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.addr0  = 8'h00 + 8'(i % 4);
      bus.wdata0 = 8'h50 + 8'(i % 4);
      bus.addr1  = 8'h80 + 8'(i % 4);
      bus.wdata1 = 8'hE0 + 8'(i % 4);
      exp0 = ((i / 4) % 2) == 0;
      #1;
      total++; if (bus.gnt0 !== exp0 || bus.gnt1 !== !exp0) begin bad++; $display("FAIL burst_gnt cycle=%0d got=%b%b exp=%b%b", i, bus.gnt0, bus.gnt1, exp0, !exp0); end
      total++; if (bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL burst_wr_en cycle=%0d got=%b exp=1", i, bus.mem_wr_en); end
    end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    #1;
    total++; if (bus.gnt1 !== 1'b1 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL burst_bubble got gnt1=%b wr=%b exp 1 0", bus.gnt1, bus.mem_wr_en); end
    tick();
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (mem[8'(k)] !== 8'h50 + 8'(k)) begin bad++; $display("FAIL burst_mem0 addr=%0d got=%h exp=%h", k, mem[8'(k)], 8'h50 + 8'(k)); end
      total++; if (mem[8'h80 + 8'(k)] !== 8'hE0 + 8'(k)) begin bad++; $display("FAIL burst_mem1 addr=%0d got=%h exp=%h", 128 + k, mem[8'h80 + 8'(k)], 8'hE0 + 8'(k)); end
    end
  endtask

  task automatic test_reset_mid_write();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 8'h3C;
    tick();
    #1;
    total++; if (bus.gnt1 !== 1'b1 || bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL mid_pre got gnt1=%b wr=%b exp 1 1", bus.gnt1, bus.mem_wr_en); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.gnt1 !== 1'b0 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL mid_drop got gnt1=%b wr=%b exp 0 0", bus.gnt1, bus.mem_wr_en); end
    @(negedge clk);
    #1;
    total++; if (mem[8'h20] !== 8'h00) begin bad++; $display("FAIL mid_nowrite got=%h exp=00", mem[8'h20]); end
    rst_n = 1'b1;
    bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0;
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL mid_tie got=%b%b exp=10", bus.gnt0, bus.gnt1); end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_release();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h80;
    tick();
    #1;
    total++; if (bus.gnt1 !== 1'b1 || bus.rdata1 !== 8'hE0) begin bad++; $display("FAIL rel_beat1 got gnt1=%b rdata1=%h exp 1 e0", bus.gnt1, bus.rdata1); end
    tick();
    bus.addr1 = 8'h81;
    #1;
    total++; if (bus.gnt1 !== 1'b1 || bus.rdata1 !== 8'hE1) begin bad++; $display("FAIL rel_beat2 got gnt1=%b rdata1=%h exp 1 e1", bus.gnt1, bus.rdata1); end
    tick();
    bus.req1 = 1'b0;
    #1;
    total++; if (bus.gnt1 !== 1'b1 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rel_bubble got gnt1=%b wr=%b exp 1 0", bus.gnt1, bus.mem_wr_en); end
    tick();
    #1;
    total++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin bad++; $display("FAIL rel_idle got=%b%b exp=00", bus.gnt0, bus.gnt1); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_single_write_read();
    test_simultaneous();
    test_contention();
    test_reset_mid_write();
    test_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
